mem_wb_stage_param: RTL

//  Parametrised MEM stage plus MEM/WB pipeline register for the pipelined CPU.

---
 rtl/mem_wb_stage_param.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage_param.sv
// mem_wb_stage_param: MEM stage with on-chip data memory plus the MEM/WB
// pipeline register.
//
// Loads can take WAIT_CYC extra cycles. While a load is outstanding, stall_m
// holds the upstream stages and the W register loads bubbles. A flush kills
// the M-stage instruction, and a valid bit travels down to writeback.
//
// Optional feature macro: BYTE_ACCESS_EN
//   When defined, alu_result_m is a byte address. byte_m and unsigned_m
//   select byte stores and sign- or zero-extended byte loads. This mode
//   assumes DATA_W >= 16.
//   When undefined, access is by word only, and byte_m and unsigned_m are
//   ignored.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   valid_m .. flush_m   M-stage instruction, control and data inputs
//   stall_m              combinational; high while a load waits on memory
//   valid_w .. pc_plus4_w  registered MEM/WB outputs
module mem_wb_stage_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RD_W     = 3,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_m,
  input  logic              regwrite_m,
  input  logic              memwrite_m,
  input  logic              memread_m,
  input  logic [1:0]        result_src_m,
  input  logic [RD_W-1:0]   rd_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [DATA_W-1:0] write_data_m,
  input  logic [DATA_W-1:0] pc_plus4_m,
  input  logic              byte_m,
  input  logic              unsigned_m,
  input  logic              flush_m,
  output logic              stall_m,
  output logic              valid_w,
  output logic              regwrite_w,
  output logic [1:0]        result_src_w,
  output logic [RD_W-1:0]   rd_w,
  output logic [DATA_W-1:0] alu_result_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic [DATA_W-1:0] pc_plus4_w
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam bit          HAS_WAIT = (WAIT_CYC != 0);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture;
  logic              store_req, load_req, mem_we;
  logic [ADDR_W-1:0] word_idx;
  logic [DATA_W-1:0] rdata, wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // A store takes priority over a load when both are set.
  assign store_req = valid_m & memwrite_m;
  assign load_req  = valid_m & ~memwrite_m & memread_m;

`ifdef BYTE_ACCESS_EN
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned LB     = $clog2(NBYTES);

  logic [LB-1:0]     lane;
  logic [DATA_W-1:0] word, merged;
  logic [7:0]        rd_byte;

  assign word_idx = alu_result_m[LB +: ADDR_W];
  assign lane     = alu_result_m[LB-1:0];

  // Lane extract for loads; read-modify-write merge for byte stores.
  always_comb begin
    word    = mem[word_idx];
    merged  = word;
    rd_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (lane == LB'(i)) begin
        rd_byte         = word[i*8 +: 8];
        merged[i*8 +: 8] = write_data_m[7:0];
      end
    end
    if (byte_m) begin
      rdata = unsigned_m ? DATA_W'(rd_byte) : {{(DATA_W-8){rd_byte[7]}}, rd_byte};
      wdata = merged;
    end else begin
      rdata = word;
      wdata = write_data_m;
    end
  end
`else
  logic unused_byte_ctl;

  assign word_idx        = alu_result_m[ADDR_W-1:0];
  assign rdata           = mem[word_idx];
  assign wdata           = write_data_m;
  assign unused_byte_ctl = byte_m ^ unsigned_m;
`endif

  // Stores commit only from IDLE. Reset and flush both suppress the write.
  assign mem_we = rst & (state_q == S_IDLE) & store_req & ~flush_m;

  // Data memory: combinational read, write on the rising edge, never cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wdata;
  end

  // State and wait-counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a load enters WAIT with the full wait count; flush abandons it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_m) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_req && HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYC);
          end
        end
        S_WAIT: begin
          cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
          if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: stall while waiting; the W register captures only when not stalled.
  always_comb begin
    stall_m = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_req && HAS_WAIT) stall_m = 1'b1;
        else                      capture = 1'b1;
      end
      S_WAIT: begin
        stall_m = (cnt_q > CNT_W'(1));
        capture = (cnt_q <= CNT_W'(1));
      end
      default: ;
    endcase
    if (!rst) stall_m = 1'b0;
  end

  // MEM/WB register. A bubble clears only valid and regwrite; other fields hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_w      <= 1'b0;
      regwrite_w   <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
    end else if (flush_m || !capture) begin
      valid_w    <= 1'b0;
      regwrite_w <= 1'b0;
    end else begin
      valid_w      <= valid_m;
      regwrite_w   <= regwrite_m & valid_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      alu_result_w <= alu_result_m;
      read_data_w  <= rdata;
      pc_plus4_w   <= pc_plus4_m;
    end
  end

endmodule
